// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    localparam int N = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Extracts a byte/half/word from a big-endian memory word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: mem_v (memory read word, byte at address+0 in [31:24]), size, uns (1 = zero-extend),
//        result (right-justified, extended load data).
module load_extend
    import lsu_pkg::*;
(
    input  logic [N-1:0] mem_v,
    input  size_t        size,
    input  logic         uns,
    output logic [N-1:0] result
);

    always_comb begin
        result = mem_v;
        case (size)
            SZ_BYTE: result = uns ? {24'h0, mem_v[31:24]}
                                  : {{24{mem_v[31]}}, mem_v[31:24]};
            SZ_HALF: result = uns ? {16'h0, mem_v[31:16]}
                                  : {{16{mem_v[31]}}, mem_v[31:16]};
            // Word loads ignore uns; the illegal size never reaches here (faulted earlier).
            default: result = mem_v;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time onto a word-wide, byte-masked, big-endian port.
// Latency: response 2 cycles after accept (0 cycles for faulted requests); one request per 3 cycles.
// Backpressure: req_ready is low while a memory access is in flight; responses cannot be stalled.
// Ports: req_* (request from execute), resp_* (one-cycle response pulse),
//        mem_address/mem_mask/mem_w (to memory), mem_v (from memory, valid one cycle after sampling).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int M = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [1:0]     req_size,
    input  logic           req_unsigned,
    input  logic [M+1:0]   req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           resp_valid,
    output logic [N-1:0]   resp_rdata,
    output logic           resp_fault,
    output logic [M+1:0]   mem_address,
    output logic [N-1:0]   mem_mask,
    output logic [N-1:0]   mem_w,
    input  logic [N-1:0]   mem_v
);

    // Total bytes in the array, expressed one bit wider than a byte address.
    localparam logic [M+2:0] MEM_BYTES = {1'b1, {(M+2){1'b0}}};

    lsu_state_t state;
    logic       write_q;
    size_t      size_q;
    logic       uns_q;

    logic       accept;
    size_t      req_sz;
    logic [2:0] nbytes;
    logic [M+2:0] end_addr;
    logic       fault;
    logic [N-1:0] lane_mask;
    logic [N-1:0] lane_w;
    logic [N-1:0] ext_data;

    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;
    assign req_sz    = size_t'(req_size);

    // Bounds check one bit wider than the address so the end-of-array sum cannot wrap.
    always_comb begin
        nbytes = 3'd4;
        case (req_sz)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr = {1'b0, req_addr} + {{M{1'b0}}, nbytes};
        fault    = (req_sz == SZ_ILL) || (end_addr > MEM_BYTES);
    end

    // Store data is left-justified so its first byte lands on address+0 (big-endian lane 31:24).
    always_comb begin
        lane_mask = '0;
        lane_w    = '0;
        if (req_write) begin
            case (req_sz)
                SZ_BYTE: begin
                    lane_mask = 32'hFF00_0000;
                    lane_w    = {req_wdata[7:0], 24'h0};
                end
                SZ_HALF: begin
                    lane_mask = 32'hFFFF_0000;
                    lane_w    = {req_wdata[15:0], 16'h0};
                end
                default: begin
                    lane_mask = 32'hFFFF_FFFF;
                    lane_w    = req_wdata;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .mem_v  (mem_v),
        .size   (size_q),
        .uns    (uns_q),
        .result (ext_data)
    );

    // The memory writes on every edge under mem_mask, so the mask is only non-zero in ISSUE
    // and is cleared asynchronously by reset to abort an in-flight store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_fault  <= 1'b0;
            resp_rdata  <= '0;
            mem_address <= '0;
            mem_mask    <= '0;
            mem_w       <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    if (accept) begin
                        write_q <= req_write;
                        size_q  <= req_sz;
                        uns_q   <= req_unsigned;
                        if (fault) begin
                            // Faults answer immediately without touching the memory.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state       <= ISSUE;
                            mem_address <= req_addr;
                            mem_mask    <= lane_mask;
                            mem_w       <= lane_w;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    mem_mask <= '0;
                    mem_w    <= '0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    resp_rdata <= write_q ? '0 : ext_data;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
